regfile_writer: RTL and testbench

Write side of the 32 × 32-bit MIPS general-purpose register file. The block accepts write-back requests from the pipeline over a valid/ready handshake and buffers them in a small in-order queue. It commits one request per cycle into the register array, with byte-lane merging for partial writes. The whole array is exposed as a flat bus, which feeds the read-side select mux. A per-register pending mask is also exported to the hazard unit.

---
 rtl/mips_rf_pkg.sv | 16 +
 rtl/rf_wr_fifo.sv | 56 +++++
 rtl/regfile_writer.sv | 67 ++++++
 tb/tb_regfile_writer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mips_rf_pkg.sv
// mips_rf_pkg: shared types, sizes and byte-mask helper for the GPR write side
package mips_rf_pkg;
    localparam int DATA_W = 32;
    localparam int NREG = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [3:0] be;
    } wr_req_t;

    function automatic logic [DATA_W-1:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction
endpackage

// File: rtl/rf_wr_fifo.sv
// rf_wr_fifo: in-order write-request queue with per-entry valid flags
module rf_wr_fifo
    import mips_rf_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push_valid,
    output logic push_ready,
    input  wr_req_t push_req,
    input  logic freeze,
    output logic pop,
    output wr_req_t head_req,
    output logic [QDEPTH-1:0] valid,
    output logic [ADDR_W-1:0] addrs [QDEPTH],
    output logic [$clog2(QDEPTH):0] count
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    wr_req_t mem [QDEPTH];
    logic [PW-1:0] head, tail;
    logic push;

    // a full queue refuses even when a pop happens on the same edge
    assign push_ready = !reset && int'(count) < QDEPTH;
    assign push = push_valid && push_ready;
    assign pop = count != '0 && !freeze;
    assign head_req = mem[head];

    for (genvar g = 0; g < QDEPTH; g++) begin : g_addr
        assign addrs[g] = mem[g].addr;
    end

    always_ff @(posedge clk)
        if (push) mem[tail] <= push_req;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (pop) begin
                head <= head + PW'(1);
                valid[head] <= 1'b0;
            end
            if (push) begin
                tail <= tail + PW'(1);
                valid[tail] <= 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
endmodule

// File: rtl/regfile_writer.sv
// regfile_writer: write side of the MIPS GPR file with queued, byte-merged commits
module regfile_writer
    import mips_rf_pkg::wr_req_t;
    import mips_rf_pkg::be_mask;
    import mips_rf_pkg::ADDR_W;
#(
    parameter int DATA_W = 32,
    parameter int NREG = 32,
    parameter int QDEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic wr_valid,
    output logic wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [3:0] wr_be,
    input  logic freeze,
    output logic [NREG*DATA_W-1:0] regs_flat,
    output logic [NREG-1:0] pending,
    output logic [$clog2(QDEPTH):0] q_count
);
    wr_req_t req, head_req;
    logic commit;
    logic [QDEPTH-1:0] valid;
    logic [ADDR_W-1:0] addrs [QDEPTH];
    logic [DATA_W-1:0] regs [1:NREG-1];
    logic [DATA_W-1:0] mask;

    assign req = {wr_addr, wr_data, wr_be};

    rf_wr_fifo #(.QDEPTH(QDEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push_valid(wr_valid),
        .push_ready(wr_ready),
        .push_req(req),
        .freeze(freeze),
        .pop(commit),
        .head_req(head_req),
        .valid(valid),
        .addrs(addrs),
        .count(q_count)
    );

    assign mask = be_mask(head_req.be);

    // R0 has no storage, so address-0 commits fall through harmlessly
    always_ff @(posedge clk or posedge reset)
        if (reset)
            for (int k = 1; k < NREG; k++) regs[k] <= '0;
        else if (commit)
            for (int k = 1; k < NREG; k++)
                if (head_req.addr == ADDR_W'(k)) regs[k] <= (regs[k] & ~mask) | (head_req.data & mask);

    always_comb begin
        pending = '0;
        for (int i = 0; i < QDEPTH; i++)
            if (valid[i]) pending[addrs[i]] = 1'b1;
        pending[0] = 1'b0;
    end

    always_comb begin
        regs_flat = '0;
        for (int k = 1; k < NREG; k++) regs_flat[k*DATA_W +: DATA_W] = regs[k];
    end
endmodule

// File: tb/tb_regfile_writer.sv
// tb_regfile_writer: directed table, corner sequences and random run against a queue model
module tb_regfile_writer;
    localparam int QD = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic wr_valid = 1'b0;
    logic wr_ready;
    logic [4:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0] wr_be = '0;
    logic freeze = 1'b0;
    logic [1023:0] regs_flat;
    logic [31:0] pending;
    logic [1:0] q_count;

    regfile_writer #(.DATA_W(32), .NREG(32), .QDEPTH(QD)) dut (
        .clk(clk),
        .reset(reset),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_be(wr_be),
        .freeze(freeze),
        .regs_flat(regs_flat),
        .pending(pending),
        .q_count(q_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] a;
        logic [31:0] d;
        logic [3:0] be;
    } req_t;

    typedef struct {
        logic v;
        logic [4:0] a;
        logic [31:0] d;
        logic [3:0] be;
        logic f;
        logic [1:0] q;
        logic [31:0] r;
        logic p;
        logic rdy;
    } vec_t;

    req_t mq[$];
    logic [31:0] mr [32];
    vec_t tbl [17];
    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        for (int k = 0; k < 32; k++) mr[k] = '0;
    endtask

    function automatic logic [1023:0] m_flat();
        logic [1023:0] f;
        for (int k = 0; k < 32; k++) f[k*32 +: 32] = mr[k];
        return f;
    endfunction

    function automatic logic [31:0] m_pend();
        logic [31:0] p = '0;
        foreach (mq[i]) if (mq[i].a != 0) p[mq[i].a] = 1'b1;
        return p;
    endfunction

    task automatic check_model();
        chk("regs_flat", regs_flat, m_flat());
        chk("pending", 1024'(pending), 1024'(m_pend()));
        chk("q_count", 1024'(q_count), 1024'(mq.size()));
        chk("wr_ready", 1024'(wr_ready), 1024'(mq.size() < QD));
    endtask

    task automatic cycle(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [3:0] be, input logic f);
        logic acc, com;
        req_t h;
        wr_valid = v;
        wr_addr = a;
        wr_data = d;
        wr_be = be;
        freeze = f;
        acc = v && mq.size() < QD;
        com = mq.size() > 0 && !f;
        @(posedge clk);
        #1;
        if (com) begin
            h = mq.pop_front();
            for (int b = 0; b < 4; b++)
                if (h.be[b] && h.a != 0) mr[h.a][8*b +: 8] = h.d[8*b +: 8];
        end
        if (acc) mq.push_back('{a: a, d: d, be: be});
        check_model();
    endtask

    initial begin
        tbl[0]  = '{1, 5, 32'hDEADBEEF, 4'hF, 0, 1, 32'h0,        1, 1};
        tbl[1]  = '{0, 5, 32'h0,        4'h0, 0, 0, 32'hDEADBEEF, 0, 1};
        tbl[2]  = '{1, 7, 32'h11223344, 4'hF, 0, 1, 32'h0,        1, 1};
        tbl[3]  = '{1, 7, 32'hAABBCCDD, 4'h5, 0, 1, 32'h11223344, 1, 1};
        tbl[4]  = '{1, 7, 32'hFFFFFFFF, 4'h0, 0, 1, 32'h11BB33DD, 1, 1};
        tbl[5]  = '{0, 7, 32'h0,        4'h0, 0, 0, 32'h11BB33DD, 0, 1};
        tbl[6]  = '{1, 0, 32'hFFFFFFFF, 4'hF, 0, 1, 32'h0,        0, 1};
        tbl[7]  = '{0, 0, 32'h0,        4'h0, 0, 0, 32'h0,        0, 1};
        tbl[8]  = '{1, 9, 32'h000000FF, 4'h1, 0, 1, 32'h0,        1, 1};
        tbl[9]  = '{1, 9, 32'h0000AA00, 4'h2, 0, 1, 32'h000000FF, 1, 1};
        tbl[10] = '{0, 9, 32'h0,        4'h0, 0, 0, 32'h0000AAFF, 0, 1};
        tbl[11] = '{1, 1, 32'h11111111, 4'hF, 1, 1, 32'h0,        1, 1};
        tbl[12] = '{1, 2, 32'h22222222, 4'hF, 1, 2, 32'h0,        1, 0};
        tbl[13] = '{1, 3, 32'h33333333, 4'hF, 1, 2, 32'h0,        0, 0};
        tbl[14] = '{1, 3, 32'h33333333, 4'hF, 0, 1, 32'h0,        0, 1};
        tbl[15] = '{1, 3, 32'h33333333, 4'hF, 0, 1, 32'h0,        1, 1};
        tbl[16] = '{0, 3, 32'h0,        4'h0, 0, 0, 32'h33333333, 0, 1};

        m_reset();
        #1;
        chk("rst_regs", regs_flat, '0);
        chk("rst_pending", 1024'(pending), '0);
        chk("rst_q_count", 1024'(q_count), '0);
        chk("rst_ready", 1024'(wr_ready), '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 1024'(wr_ready), 1024'(1));

        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].be, tbl[i].f);
            chk($sformatf("tbl%0d_q", i), 1024'(q_count), 1024'(tbl[i].q));
            chk($sformatf("tbl%0d_reg", i), 1024'(regs_flat[tbl[i].a*32 +: 32]), 1024'(tbl[i].r));
            chk($sformatf("tbl%0d_pend", i), 1024'(pending[tbl[i].a]), 1024'(tbl[i].p));
            chk($sformatf("tbl%0d_rdy", i), 1024'(wr_ready), 1024'(tbl[i].rdy));
        end
        chk("r1_after_tbl", 1024'(regs_flat[32 +: 32]), 1024'(32'h11111111));
        chk("r2_after_tbl", 1024'(regs_flat[64 +: 32]), 1024'(32'h22222222));

        cycle(1, 4, 32'h44444444, 4'hF, 1);
        cycle(1, 6, 32'h66666666, 4'hF, 1);
        chk("mid_q_full", 1024'(q_count), 1024'(2));
        chk("mid_pend", 1024'(pending), 1024'(32'h50));
        #2;
        reset = 1'b1;
        #1;
        chk("async_regs", regs_flat, '0);
        chk("async_q_count", 1024'(q_count), '0);
        chk("async_pending", 1024'(pending), '0);
        chk("async_ready", 1024'(wr_ready), '0);
        m_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) cycle(0, 0, 32'h0, 4'h0, 0);
        chk("no_late_r4", 1024'(regs_flat[128 +: 32]), '0);
        chk("no_late_r6", 1024'(regs_flat[192 +: 32]), '0);

        repeat (3000) begin
            logic [4:0] a;
            a = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            cycle($urandom_range(0, 3) != 0, a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 4) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
